// File: rtl/ps2_scan_controller.sv
// PS/2 scan sequencer: frame check, E0/F0 prefix decoding, event FIFO and a
// stalled-frame watchdog that tells the receiver to drop a partial frame.
module ps2_scan_controller #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 7500
) (
  input  logic                         clock,
  input  logic                         reset_neg,
  input  logic                         neg_edge,
  input  logic                         frame_valid,
  input  logic [10:0]                  frame_data,
  input  logic                         event_ready,
  output logic                         rx_clear,
  output logic                         event_valid,
  output logic [7:0]                   event_code,
  output logic                         event_extended,
  output logic                         event_break,
  output logic                         event_dropped,
  output logic                         frame_error,
  output logic [7:0]                   error_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  state_t          state, state_n;
  event_t          fifo_mem   [FIFO_DEPTH];
  event_t          fifo_mem_n [FIFO_DEPTH];
  logic [CW-1:0]   count_n;
  logic            frame_active;
  logic [WW-1:0]   wd_cnt;

  logic [7:0]      data_c;
  logic            frame_ok_c;
  logic            timeout_c;
  logic            emit_c;
  logic            proto_err_c;
  logic            error_c;
  event_t          evt_c;
  logic            full_c;
  logic            pop_c;
  logic            push_ok_c;
  logic            drop_c;
  logic [AW-1:0]   wr_idx_c;

  assign data_c     = frame_data[8:1];
  assign frame_ok_c = ~frame_data[0] & frame_data[10] & (^frame_data[9:1]);

  // A frame_valid or a fresh neg_edge in the expiry cycle means the bus is alive.
  assign timeout_c  = frame_active & ~frame_valid & ~neg_edge &
                      (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      frame_active <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      frame_active <= neg_edge | (frame_active & ~frame_valid & ~timeout_c);
      if (neg_edge || !frame_active || frame_valid || timeout_c) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Prefix decoder: accumulates E0/F0 and emits one event per key code.
  always_comb begin
    state_n     = state;
    emit_c      = 1'b0;
    proto_err_c = 1'b0;
    evt_c       = '{ext: 1'b0, brk: 1'b0, code: data_c};
    if (timeout_c) begin
      state_n = IDLE;
    end else if (frame_valid) begin
      if (!frame_ok_c) begin
        state_n = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (data_c == CODE_EXT)      state_n = EXT;
            else if (data_c == CODE_BRK) state_n = BRK;
            else                         emit_c  = 1'b1;
          end
          EXT: begin
            if (data_c == CODE_BRK) begin
              state_n = EXT_BRK;
            end else if (data_c != CODE_EXT) begin
              emit_c    = 1'b1;
              evt_c.ext = 1'b1;
              state_n   = IDLE;
            end
          end
          BRK: begin
            if (data_c == CODE_EXT) begin
              proto_err_c = 1'b1;
              state_n     = IDLE;
            end else if (data_c != CODE_BRK) begin
              emit_c    = 1'b1;
              evt_c.brk = 1'b1;
              state_n   = IDLE;
            end
          end
          EXT_BRK: begin
            state_n = IDLE;
            if (data_c == CODE_EXT || data_c == CODE_BRK) begin
              proto_err_c = 1'b1;
            end else begin
              emit_c    = 1'b1;
              evt_c.ext = 1'b1;
              evt_c.brk = 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  assign error_c   = timeout_c | (frame_valid & ~frame_ok_c) | proto_err_c;
  assign full_c    = (fifo_count == CW'(FIFO_DEPTH));
  assign pop_c     = event_valid & event_ready;
  assign push_ok_c = emit_c & (~full_c | pop_c);
  assign drop_c    = emit_c & full_c & ~pop_c;
  assign wr_idx_c  = pop_c ? AW'(fifo_count - CW'(1)) : AW'(fifo_count);

  // Shifting FIFO keeps the head in entry 0 so event fields come straight from flops.
  always_comb begin
    fifo_mem_n = fifo_mem;
    if (pop_c) begin
      for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
        fifo_mem_n[AW'(i)] = fifo_mem[AW'(i + 1)];
      end
      fifo_mem_n[AW'(FIFO_DEPTH - 1)] = '0;
    end
    if (push_ok_c) begin
      fifo_mem_n[wr_idx_c] = evt_c;
    end
    count_n = fifo_count + CW'(push_ok_c) - CW'(pop_c);
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[AW'(i)] <= '0;
      end
      fifo_count    <= '0;
      event_valid   <= 1'b0;
      event_dropped <= 1'b0;
      frame_error   <= 1'b0;
      rx_clear      <= 1'b0;
      error_count   <= '0;
    end else begin
      fifo_mem      <= fifo_mem_n;
      fifo_count    <= count_n;
      event_valid   <= (count_n != '0);
      event_dropped <= drop_c;
      frame_error   <= error_c;
      rx_clear      <= timeout_c;
      if (error_c && error_count != 8'hFF) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

  assign event_code     = fifo_mem[0].code;
  assign event_extended = fifo_mem[0].ext;
  assign event_break    = fifo_mem[0].brk;

endmodule
